// File: rtl/aes_ctr_pkg.sv
// aes_ctr_pkg: shared types and helpers for the AES counter-mode sequencer.
// Contents: sequencer state encoding, default block-count width, and the
// 64-bit counter increment used to step the counter block.
package aes_ctr_pkg;

  // Default width of the block count and the block index.
  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,  // waiting for a start command
    ST_ISSUE = 3'd1,  // pulsing cipher_next for the current counter block
    ST_WAIT  = 3'd2,  // encipher in flight or result waiting for buffer space
    ST_FLUSH = 3'd3,  // all blocks issued, waiting for the last one to leave
    ST_DRAIN = 3'd4   // aborted mid-operation, letting the encipher finish
  } state_t;

  // Counter step: low 64 bits wrap modulo 2^64, upper 64 bits are untouched.
  function automatic logic [127:0] inc64(input logic [127:0] blk);
    inc64 = {blk[127:64], blk[63:0] + 64'd1};
  endfunction

endpackage

// File: rtl/aes_ctr_outbuf.sv
// aes_ctr_outbuf: one-entry valid/ready holding register for keystream blocks.
// Ports: clk/reset_n; i_clr synchronous flush; i_cap/i_cap_dat/i_cap_idx load
// a new entry; i_rdy downstream accept; o_vld/o_dat/o_idx the held entry.
module aes_ctr_outbuf
  import aes_ctr_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clr,
  input  logic             i_cap,
  input  logic [127:0]     i_cap_dat,
  input  logic [CNT_W-1:0] i_cap_idx,
  input  logic             i_rdy,
  output logic             o_vld,
  output logic [127:0]     o_dat,
  output logic [CNT_W-1:0] o_idx
);

  logic             r_vld;
  logic [127:0]     r_dat;
  logic [CNT_W-1:0] r_idx;

  // Priority: flush, then capture, then drain. A capture in the same cycle
  // as a drain keeps the entry valid and replaces its contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld <= 1'b0;
      r_dat <= '0;
      r_idx <= '0;
    end else if (i_clr) begin
      r_vld <= 1'b0;
    end else if (i_cap) begin
      r_vld <= 1'b1;
      r_dat <= i_cap_dat;
      r_idx <= i_cap_idx;
    end else if (i_rdy) begin
      r_vld <= 1'b0;
    end
  end

  assign o_vld = r_vld;
  assign o_dat = r_dat;
  assign o_idx = r_idx;

endmodule

// File: rtl/aes_ctr_sequencer.sv
// aes_ctr_sequencer: drives the encipher block once per counter value and
// buffers each result as a keystream block with index.
// Ports: command (i_start/i_abort/i_keylen/i_ctr_init/i_num_blocks, o_busy/
// o_done), encipher handshake (o_cipher_*, i_cipher_*), keystream (o_ks_*, i_ks_ready).
module aes_ctr_sequencer
  import aes_ctr_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_keylen,
  input  logic [127:0]     i_ctr_init,
  input  logic [CNT_W-1:0] i_num_blocks,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_cipher_next,
  output logic             o_cipher_keylen,
  output logic [127:0]     o_cipher_block,
  input  logic             i_cipher_ready,
  input  logic [127:0]     i_cipher_result,
  output logic             o_ks_valid,
  input  logic             i_ks_ready,
  output logic [127:0]     o_ks_data,
  output logic [CNT_W-1:0] o_ks_index
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_cipher_next;
  logic [127:0]     r_ctr;
  logic [CNT_W-1:0] r_remaining;
  logic [CNT_W-1:0] r_issued_idx;
  logic             r_keylen;

  logic             w_start_acc;
  logic             w_buf_free;
  logic             w_capture;
  logic             w_clr;
  logic             w_ks_valid;

  // A start that coincides with abort is dropped, as is any start while busy.
  assign w_start_acc = (r_state == ST_IDLE) && i_start && !i_abort;

  // The buffer can take a new block if it is empty or is being emptied now.
  assign w_buf_free  = !w_ks_valid || i_ks_ready;

  // While the buffer is full the encipher result simply waits on its outputs;
  // the encipher block keeps it stable while cipher_ready is high.
  assign w_capture   = (r_state == ST_WAIT) && i_cipher_ready && !i_abort && w_buf_free;

  // Abort empties the buffer from any active state; in IDLE it is a no-op.
  assign w_clr       = i_abort && (r_state != ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_done_nxt    = 1'b0;
    w_cipher_next = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start_acc) begin
          // An empty run completes immediately without ever going busy.
          if (i_num_blocks == '0) w_done_nxt = 1'b1;
          else                    w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cipher_next = 1'b1;
          w_state_nxt   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_abort) begin
          // An operation is in flight; its result must be let through first.
          w_state_nxt = ST_DRAIN;
        end else if (w_capture) begin
          w_state_nxt = (r_remaining > CNT_W'(1)) ? ST_ISSUE : ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_buf_free) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (i_cipher_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Run context: latched on an accepted start, stepped on every capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ctr        <= '0;
      r_remaining  <= '0;
      r_issued_idx <= '0;
      r_keylen     <= 1'b0;
    end else if (w_start_acc) begin
      r_ctr        <= i_ctr_init;
      r_remaining  <= i_num_blocks;
      r_issued_idx <= '0;
      r_keylen     <= i_keylen;
    end else if (w_capture) begin
      r_ctr        <= inc64(r_ctr);
      r_remaining  <= r_remaining - CNT_W'(1);
      r_issued_idx <= r_issued_idx + CNT_W'(1);
    end
  end

  aes_ctr_outbuf #(
    .CNT_W (CNT_W)
  ) u_outbuf (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_clr     (w_clr),
    .i_cap     (w_capture),
    .i_cap_dat (i_cipher_result),
    .i_cap_idx (r_issued_idx),
    .i_rdy     (i_ks_ready),
    .o_vld     (w_ks_valid),
    .o_dat     (o_ks_data),
    .o_idx     (o_ks_index)
  );

  assign o_busy          = (r_state != ST_IDLE);
  assign o_done          = r_done;
  assign o_cipher_next   = w_cipher_next;
  assign o_cipher_keylen = r_keylen;
  // The counter only moves on capture, so the block is stable from ISSUE
  // through the capture cycle.
  assign o_cipher_block  = r_ctr;
  assign o_ks_valid      = w_ks_valid;

endmodule

// File: tb/tb_aes_ctr_sequencer.sv
// tb_aes_ctr_sequencer: directed bench for aes_ctr_sequencer with a
// stand-in encipher (bitwise complement, programmable latency) and a queue
// model of the expected counter blocks and keystream of each run.
module tb_aes_ctr_sequencer;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             i_start, i_abort, i_keylen;
  logic [127:0]     i_ctr_init;
  logic [CNT_W-1:0] i_num_blocks;
  logic             o_busy, o_done, o_cipher_next, o_cipher_keylen;
  logic [127:0]     o_cipher_block;
  logic             i_cipher_ready;
  logic [127:0]     i_cipher_result;
  logic             o_ks_valid;
  logic             i_ks_ready;
  logic [127:0]     o_ks_data;
  logic [CNT_W-1:0] o_ks_index;

  always #5 clk = ~clk;

  aes_ctr_sequencer #(.CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_start         (i_start),
    .i_abort         (i_abort),
    .i_keylen        (i_keylen),
    .i_ctr_init      (i_ctr_init),
    .i_num_blocks    (i_num_blocks),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_cipher_next   (o_cipher_next),
    .o_cipher_keylen (o_cipher_keylen),
    .o_cipher_block  (o_cipher_block),
    .i_cipher_ready  (i_cipher_ready),
    .i_cipher_result (i_cipher_result),
    .o_ks_valid      (o_ks_valid),
    .i_ks_ready      (i_ks_ready),
    .o_ks_data       (o_ks_data),
    .o_ks_index      (o_ks_index)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [127:0]     dat;
    logic [CNT_W-1:0] idx;
  } ks_t;

  ks_t          exp_ks[$];
  logic [127:0] exp_blk[$];
  logic         exp_keylen = 1'b0;
  logic         zero_start = 1'b0;
  int           cipher_lat = 2;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string what);
    vectors++;
    miscompares++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Counter block i of a run: low half advanced by i modulo 2^64.
  function automatic logic [127:0] blk_of(input logic [127:0] ctr, input int i);
    logic [63:0] lo;
    lo = ctr[63:0] + 64'(i);
    return {ctr[127:64], lo};
  endfunction

  // Stand-in encipher. Ready drops in the cycle cipher_next is seen and
  // returns after cipher_lat more cycles with the complemented block.
  initial begin
    int           cnt;
    logic [127:0] pend;
    cnt = 0;
    pend = '0;
    i_cipher_ready  = 1'b1;
    i_cipher_result = '0;
    forever begin
      @(negedge clk); #1;
      if (!reset_n) begin
        i_cipher_ready  = 1'b1;
        i_cipher_result = '0;
        cnt = 0;
      end else if (o_cipher_next) begin
        i_cipher_ready  = 1'b0;
        i_cipher_result = '0;
        pend = ~o_cipher_block;
        cnt  = cipher_lat;
      end else if (!i_cipher_ready) begin
        cnt--;
        if (cnt <= 0) begin
          i_cipher_ready  = 1'b1;
          i_cipher_result = pend;
        end
      end
    end
  end

  // Per-cycle compare against the model queues.
  initial begin
    logic             done_due, prev_hold;
    logic [127:0]     prev_dat;
    logic [CNT_W-1:0] prev_idx;
    ks_t              e;
    logic [127:0]     b;
    done_due = 1'b0; prev_hold = 1'b0; prev_dat = '0; prev_idx = '0;
    forever begin
      @(negedge clk); #2;
      if (!reset_n) begin
        done_due  = 1'b0;
        prev_hold = 1'b0;
      end else begin
        chk("done_pulse", o_done, done_due);
        done_due = 1'b0;
        if (prev_hold) begin
          chk("hold_valid", o_ks_valid, 1'b1);
          chk("hold_data", o_ks_data, prev_dat);
          chk("hold_index", o_ks_index, prev_idx);
        end
        if (o_cipher_next) begin
          if (exp_blk.size() == 0) begin
            fail("cipher_next", "asserted with no block outstanding, required 0");
          end else begin
            b = exp_blk.pop_front();
            chk("cipher_block", o_cipher_block, b);
            chk("cipher_keylen", o_cipher_keylen, exp_keylen);
          end
        end
        if (o_ks_valid && i_ks_ready) begin
          if (exp_ks.size() == 0) begin
            fail("ks_handshake", "block delivered with none expected");
          end else begin
            e = exp_ks.pop_front();
            chk("ks_data", o_ks_data, e.dat);
            chk("ks_index", o_ks_index, e.idx);
            if (exp_ks.size() == 0 && exp_blk.size() == 0) done_due = 1'b1;
          end
        end
        if (zero_start) done_due = 1'b1;
        prev_hold = o_ks_valid && !i_ks_ready && !i_abort;
        prev_dat  = o_ks_data;
        prev_idx  = o_ks_index;
      end
    end
  end

  // Advance to the next cycle with one-cycle command inputs returned low.
  task automatic cyc();
    @(negedge clk);
    i_start    = 1'b0;
    i_abort    = 1'b0;
    zero_start = 1'b0;
  endtask

  task automatic start_run(input logic [127:0] ctr, input int n, input logic kl, input bit expect_run);
    i_start      = 1'b1;
    i_ctr_init   = ctr;
    i_num_blocks = CNT_W'(n);
    i_keylen     = kl;
    if (expect_run) begin
      exp_keylen = kl;
      for (int i = 0; i < n; i++) begin
        exp_blk.push_back(blk_of(ctr, i));
        exp_ks.push_back(ks_t'{dat: ~blk_of(ctr, i), idx: CNT_W'(i)});
      end
      if (n == 0) zero_start = 1'b1;
    end
  endtask

  // sel: 0 ks_valid, 1 done, 2 not busy, 3 cipher_next
  task automatic wait_ev(input string name, input int sel, input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      cyc(); #3;
      case (sel)
        0: seen = o_ks_valid;
        1: seen = o_done;
        2: seen = !o_busy;
        default: seen = o_cipher_next;
      endcase
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL %s: event absent after %0d cycles, required present", name, budget);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, o_busy, 1'b0);
    chk({tag, "_done"}, o_done, 1'b0);
    chk({tag, "_next"}, o_cipher_next, 1'b0);
    chk({tag, "_keylen"}, o_cipher_keylen, 1'b0);
    chk({tag, "_block"}, o_cipher_block, 128'h0);
    chk({tag, "_ks_valid"}, o_ks_valid, 1'b0);
    chk({tag, "_ks_data"}, o_ks_data, 128'h0);
    chk({tag, "_ks_index"}, o_ks_index, 128'h0);
  endtask

  initial begin
    logic [127:0] seen_blk [3];
    int           nxt_cnt;
    bit           seen;

    reset_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_keylen = 1'b0;
    i_ctr_init = '0; i_num_blocks = '0; i_ks_ready = 1'b0;
    repeat (3) @(negedge clk);
    #3 chk_reset_outputs("reset");
    cyc(); reset_n = 1'b1;
    cyc();

    // Single block, hand-computed complement of the counter block.
    cipher_lat = 3; i_ks_ready = 1'b1;
    cyc(); start_run(128'h00112233445566778899aabbccddeeff, 1, 1'b1, 1'b1);
    cyc(); #3;
    chk("a_busy_s1", o_busy, 1'b1);
    chk("a_next_s1", o_cipher_next, 1'b1);
    chk("a_block_s1", o_cipher_block, 128'h00112233445566778899aabbccddeeff);
    chk("a_keylen", o_cipher_keylen, 1'b1);
    cyc(); #3;
    chk("a_next_s2", o_cipher_next, 1'b0);
    wait_ev("a_ks_valid", 0, 20);
    chk("a_ks_data", o_ks_data, 128'hffeeddccbbaa99887766554433221100);
    chk("a_ks_index", o_ks_index, 128'h0);
    cyc(); #3;
    chk("a_done", o_done, 1'b1);
    chk("a_busy_done", o_busy, 1'b0);
    cyc(); #3;
    chk("a_done_once", o_done, 1'b0);

    // Low-half wrap of the counter.
    cipher_lat = 2;
    cyc(); start_run({64'h0123456789abcdef, 64'hfffffffffffffffe}, 3, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      wait_ev("b_next", 3, 20);
      seen_blk[i] = o_cipher_block;
    end
    chk("b_blk0", seen_blk[0], 128'h0123456789abcdef_fffffffffffffffe);
    chk("b_blk1", seen_blk[1], 128'h0123456789abcdef_ffffffffffffffff);
    chk("b_blk2", seen_blk[2], 128'h0123456789abcdef_0000000000000000);
    wait_ev("b_done", 1, 30);

    // Long backpressure: one buffered block plus one held in the encipher.
    i_ks_ready = 1'b0;
    cyc(); start_run(128'hdeadbeef000000000000000000000010, 4, 1'b1, 1'b1);
    nxt_cnt = 0;
    for (int k = 0; k < 200; k++) begin
      cyc(); #3;
      if (o_cipher_next) nxt_cnt++;
    end
    chk("c_next_count", nxt_cnt, 2);
    chk("c_valid", o_ks_valid, 1'b1);
    chk("c_index", o_ks_index, 128'h0);
    cyc(); i_ks_ready = 1'b1;
    wait_ev("c_done", 1, 50);
    chk("c_left", exp_ks.size(), 0);

    // Alternating ready: captures coincide with drains.
    cipher_lat = 1;
    cyc(); start_run(128'h0000000000000001_00000000000000f0, 6, 1'b0, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      cyc(); i_ks_ready = k[0]; #3;
      seen = o_done;
    end
    if (!seen) fail("d_done", "no done within 200 cycles, required done");
    chk("d_left", exp_ks.size(), 0);

    // Abort while an operation is in flight.
    cipher_lat = 6; i_ks_ready = 1'b0;
    cyc(); start_run(128'h55555555555555550000000000000100, 3, 1'b1, 1'b1);
    wait_ev("e_first", 0, 30);
    cyc(); i_abort = 1'b1; exp_ks.delete(); exp_blk.delete();
    cyc(); #3;
    chk("e_valid_cleared", o_ks_valid, 1'b0);
    chk("e_busy_drain", o_busy, 1'b1);
    wait_ev("e_idle", 2, 20);
    chk("e_no_done", o_done, 1'b0);
    cipher_lat = 2; i_ks_ready = 1'b1;
    cyc(); start_run(128'h0f0e0d0c0b0a09080706050403020100, 2, 1'b0, 1'b1);
    wait_ev("e_rerun_done", 1, 40);
    chk("e_rerun_left", exp_ks.size(), 0);

    // Zero-length run.
    cyc(); start_run(128'h1234, 0, 1'b0, 1'b1);
    cyc(); #3;
    chk("f_done", o_done, 1'b1);
    chk("f_busy", o_busy, 1'b0);
    chk("f_next", o_cipher_next, 1'b0);
    cyc(); #3;
    chk("f_done_once", o_done, 1'b0);
    chk("f_busy2", o_busy, 1'b0);

    // Start while busy, then start with abort in IDLE.
    cipher_lat = 4;
    cyc(); start_run(128'hcafef00d000000000000000000000040, 2, 1'b1, 1'b1);
    cyc(); cyc();
    cyc(); start_run(128'h99999999999999999999999999999999, 5, 1'b0, 1'b0);
    wait_ev("g_done", 1, 40);
    chk("g_left", exp_ks.size(), 0);
    cyc(); start_run(128'h77, 3, 1'b0, 1'b0); i_abort = 1'b1;
    cyc(); #3;
    chk("g_abort_start_busy", o_busy, 1'b0);
    chk("g_abort_start_next", o_cipher_next, 1'b0);

    // Reset in the middle of a run, then a clean run.
    cipher_lat = 3; i_ks_ready = 1'b0;
    cyc(); start_run(128'habababababababab00000000000000aa, 5, 1'b1, 1'b1);
    repeat (12) cyc();
    reset_n = 1'b0; exp_ks.delete(); exp_blk.delete();
    #3 chk_reset_outputs("midreset");
    cyc(); cyc(); reset_n = 1'b1;
    i_ks_ready = 1'b1;
    cyc(); start_run(128'h00000000000000000000000000000005, 2, 1'b0, 1'b1);
    wait_ev("h_done", 1, 40);
    chk("h_left", exp_ks.size(), 0);

    repeat (3) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required finish");
    $fatal(1);
  end

endmodule

// File: doc/aes_ctr_sequencer.md
# aes_ctr_sequencer

Counter-mode sequencer that drives the AES encipher round block through its next/ready handshake to produce a run of keystream blocks. It latches a 128-bit initial counter block and a block count, and issues one encipher operation per counter value. Each result goes into a one-entry output buffer with a valid/ready handshake, and the counter is incremented after each block. It sits between the core's command registers and the encipher block, and overlaps the next encipher operation with downstream consumption of the previous result.

## Interface
- CNT_W, 16: width of block count and block index.
- clk  in  1  clock, all state rising-edge.
- reset_n  in  1  reset, asynchronous, active-low.
- start  in  1  command pulse; accepted only in IDLE.
- abort  in  1  cancel current run.
- keylen  in  1  0 = AES-128, 1 = AES-256; sampled on accepted start.
- ctr_init  in  128  initial counter block; sampled on accepted start.
- num_blocks  in  CNT_W  blocks to generate; sampled on accepted start.
- busy  out  1  high from accepted start until return to IDLE.
- done  out  1  one-cycle pulse when a run completes normally.
- cipher_next  out  1  one-cycle start pulse to the encipher block.
- cipher_keylen  out  1  latched keylen.
- cipher_block  out  128  current counter block; input to the cipher.
- cipher_ready  in  1  encipher ready; low from the cycle after cipher_next until the result is valid.
- cipher_result  in  128  encipher output; stable while cipher_ready is high.
- ks_valid  out  1  output buffer holds a keystream block.
- ks_ready  in  1  downstream accepts the block.
- ks_data  out  128  keystream block.
- ks_index  out  CNT_W  zero-based index of ks_data within the run.

## Operation
- Registers: state, ctr_reg (128), remaining (CNT_W), issued_idx (CNT_W), keylen_reg, buffer (ks_data, ks_index, ks_valid).
- States: IDLE, ISSUE, WAIT, FLUSH, DRAIN.
- IDLE, start=1, abort=0:
  - Latch ctr_init, keylen and num_blocks; clear issued_idx.
  - num_blocks=0: pulse done next cycle, stay IDLE, busy stays 0.
  - Otherwise go to ISSUE.
- ISSUE: cipher_next = (state==ISSUE) && !abort; go to WAIT.
- WAIT, cipher_ready=1: capture if the buffer is empty or drains this cycle (ks_valid && ks_ready). On capture:
  - ks_data <= cipher_result; ks_index <= issued_idx; ks_valid <= 1.
  - ctr_reg increments; issued_idx++; remaining--.
  - Next state is ISSUE if remaining before the decrement was >1, else FLUSH.
- WAIT, buffer full and not draining: hold in WAIT. The encipher result stays stable.
- FLUSH: when ks_valid=0 or ks_ready=1 → done pulse next cycle, go to IDLE.
- Counter increment: low 64 bits +1 modulo 2^64; upper 64 bits unchanged.
- ks_valid clears on ks_ready unless a new capture happens in the same cycle. Capture wins, so ks_valid stays 1 with the new data.
- Abort handling:
  - In IDLE: no effect, and start is ignored that cycle.
  - In ISSUE or FLUSH: go to IDLE next cycle.
  - In WAIT: go to DRAIN. DRAIN waits for cipher_ready=1, then goes to IDLE and discards the result.
  - In every case ks_valid clears the next cycle and there is no done pulse.
- start while busy is ignored. busy = (state != IDLE).
- cipher_block = ctr_reg. It holds from ISSUE through the capture cycle.

## Timing
- Reset values: busy 0, done 0, cipher_next 0, cipher_keylen 0, cipher_block 0, ks_valid 0, ks_data 0, ks_index 0; state IDLE.
- Start accepted at cycle S:
  - busy=1 and cipher_next=1 at S+1.
  - WAIT from S+2.
- Capture at cycle C (cipher_ready=1 in WAIT):
  - ks_valid=1 at C+1.
  - Following cipher_next at C+1 if blocks remain.
- Per-block overhead is 2 cycles beyond cipher latency when the consumer keeps pace.
- Done: pulse 1 cycle after the last buffer handshake; busy=0 in the same cycle.
- num_blocks = 2^CNT_W − 1 is supported; ks_index does not wrap within a run.

## Structure
- aes_ctr_pkg: state encoding, CNT_W default, inc64 function.
- One sub-module, aes_ctr_outbuf: single-entry valid/ready buffer with capture-wins-over-drain and a synchronous clear (abort).

## Test plan
- Integrated with aes_encipher_block and round-key model:
  - Stimulus: key 000102…0f, ctr_init 00112233445566778899aabbccddeeff, num_blocks=1, ks_ready=1.
  - Response: ks_data 69c4e0d86a7b0430d8cdb78070b4c55a, ks_index 0, done one cycle after the handshake.
- Wrap: ctr_init low 64 bits = FFFFFFFF_FFFFFFFE, num_blocks=3 → cipher_block low 64 bits sequence …FE, …FF, 0; upper 64 bits unchanged.
- Backpressure: num_blocks=4, ks_ready=0 for 200 cycles → at most one cipher_next beyond the buffered block; then ks_ready=1 → indices 0,1,2,3 in order, no loss.
- Abort in WAIT → ks_valid=0 next cycle; busy stays 1 until cipher_ready; no done; a new start afterwards runs normally.
- num_blocks=0 → done pulse at S+1, cipher_next never asserted, busy stays 0.
- Reset mid-run → all outputs at reset values; start ignored while busy, start and abort in the same cycle ignored.
